// File: rtl/qpsk_symbol_upsampler.sv
`default_nettype none
// ============================================================================
// qpsk_symbol_upsampler : repeats or zero-stuffs each QPSK symbol SPS times
// onto an AXI-Stream DAC sample stream.            Revision: 1.0
// ============================================================================
module qpsk_symbol_upsampler #(
  parameter int SPS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] axis_in_tdata,
  input  logic        axis_in_tvalid,
  input  logic        axis_in_tlast,
  output logic        axis_in_tready,
  output logic [31:0] axis_out_tdata,
  output logic        axis_out_tvalid,
  output logic        axis_out_tlast,
  input  logic        axis_out_tready,
  input  logic        cfg_zero_stuff,
  output logic [15:0] underflow_cnt
);

  localparam logic [3:0] LAST_PHASE = 4'(SPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  phase;
  logic [31:0] sym;
  logic        sym_last;
  logic        sym_zs;

  logic [31:0] fifo_data [2];
  logic [1:0]  fifo_last;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;

  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        out_upd;
  logic [31:0] head_data;
  logic        head_last;

  assign fifo_empty     = (fifo_count == 2'd0);
  assign axis_in_tready = (fifo_count < 2'd2);
  assign push           = axis_in_tvalid && axis_in_tready;
  assign head_data      = fifo_data[rd_ptr];
  assign head_last      = fifo_last[rd_ptr];
  assign out_upd        = !axis_out_tvalid || axis_out_tready;

  // A symbol leaves the FIFO only when the output register is free to take
  // its phase-0 beat, so pop and load always coincide.
  always_comb begin
    pop = 1'b0;
    if (out_upd && !fifo_empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        FILL:    pop = 1'b1;
        RUN:     pop = (phase == LAST_PHASE);
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= axis_in_tdata;
      fifo_last[wr_ptr] <= axis_in_tlast;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      phase           <= 4'd0;
      sym             <= 32'd0;
      sym_last        <= 1'b0;
      sym_zs          <= 1'b0;
      axis_out_tdata  <= 32'd0;
      axis_out_tvalid <= 1'b0;
      axis_out_tlast  <= 1'b0;
      underflow_cnt   <= 16'd0;
    end else if (out_upd) begin
      if (pop) begin
        // SPS >= 2, so phase 0 is never the tlast beat
        state           <= RUN;
        phase           <= 4'd0;
        sym             <= head_data;
        sym_last        <= head_last;
        sym_zs          <= cfg_zero_stuff;
        axis_out_tdata  <= head_data;
        axis_out_tvalid <= 1'b1;
        axis_out_tlast  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            axis_out_tdata  <= 32'd0;
            axis_out_tvalid <= 1'b0;
            axis_out_tlast  <= 1'b0;
          end
          RUN: begin
            if (phase == LAST_PHASE) begin
              phase          <= 4'd0;
              axis_out_tdata <= 32'd0;
              axis_out_tlast <= 1'b0;
              if (sym_last) begin
                state           <= IDLE;
                axis_out_tvalid <= 1'b0;
              end else begin
                state           <= FILL;
                axis_out_tvalid <= 1'b1;
                if (underflow_cnt != 16'hFFFF)
                  underflow_cnt <= underflow_cnt + 16'd1;
              end
            end else begin
              phase           <= phase + 4'd1;
              axis_out_tdata  <= sym_zs ? 32'd0 : sym;
              axis_out_tvalid <= 1'b1;
              axis_out_tlast  <= sym_last && (phase + 4'd1 == LAST_PHASE);
            end
          end
          FILL: begin
            axis_out_tdata  <= 32'd0;
            axis_out_tvalid <= 1'b1;
            axis_out_tlast  <= 1'b0;
          end
          default: begin
            state           <= IDLE;
            phase           <= 4'd0;
            axis_out_tdata  <= 32'd0;
            axis_out_tvalid <= 1'b0;
            axis_out_tlast  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/qpsk_symbol_upsampler.md
QPSK_SYMBOL_UPSAMPLER -- requirements
Module: qpsk_symbol_upsampler

Interface
REQ-001 SHALL have parameter: SPS, default 4, samples per symbol, legal range 2..16.
REQ-002 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: axis_in_tdata  in  32  QPSK symbol {I[31:16], Q[15:0]} from the QPSK data converter.
REQ-005 SHALL have port: axis_in_tvalid  in  1  input symbol valid.
REQ-006 SHALL have port: axis_in_tlast  in  1  symbol is the last of a burst.
REQ-007 SHALL have port: axis_in_tready  out  1  input accepted when tvalid&&tready.
REQ-008 SHALL have port: axis_out_tdata  out  32  DAC sample {I,Q}.
REQ-009 SHALL have port: axis_out_tvalid  out  1  output sample valid.
REQ-010 SHALL have port: axis_out_tlast  out  1  last sample of the last symbol of a burst.
REQ-011 SHALL have port: axis_out_tready  in  1  DAC accepts sample.
REQ-012 SHALL have port: cfg_zero_stuff  in  1  0 = hold symbol for SPS samples, 1 = symbol then SPS-1 zero samples.
REQ-013 SHALL have port: underflow_cnt  out  16  count of mid-burst underflow events, saturating.

Function
REQ-014 SHALL buffer input symbols (data+tlast) in a 2-entry FIFO; axis_in_tready = FIFO occupancy < 2.
REQ-015 SHALL support simultaneous push and pop; occupancy unchanged; no entry lost or duplicated.
REQ-016 SHALL register all outputs; the output register updates only when !axis_out_tvalid || axis_out_tready; tdata/tvalid/tlast SHALL be stable while tvalid=1 and tready=0.
REQ-017 SHALL implement FSM states IDLE, RUN, FILL.
REQ-018 IDLE: axis_out_tvalid=0; when FIFO non-empty, pop symbol, load output with phase 0, go RUN.
REQ-019 Latency: symbol accepted at edge E into empty FIFO in IDLE SHALL appear on axis_out_tdata with tvalid=1 after edge E+1.
REQ-020 RUN: 4-bit phase counter advances 0..SPS-1 on each output handshake.
REQ-021 RUN output: phase 0 = symbol; phase>0 = symbol if cfg_zero_stuff=0, else 32'h0.
REQ-022 axis_out_tlast SHALL be 1 only at phase SPS-1 of a symbol tagged tlast.
REQ-023 At handshake of phase SPS-1: FIFO non-empty -> pop, next beat is new symbol phase 0 (no gap); empty and current tagged last -> IDLE; empty and not last -> FILL, underflow_cnt +1.
REQ-024 FILL: axis_out_tvalid=1, tdata=32'h0, tlast=0; when FIFO non-empty at an output-register update, pop and load phase 0, go RUN.
REQ-025 underflow_cnt SHALL increment once per RUN->FILL transition and saturate at 16'hFFFF.
REQ-026 cfg_zero_stuff SHALL be sampled at each phase-0 load and held for that symbol.
REQ-027 Throughput: back-to-back input at 1 symbol per SPS cycles with axis_out_tready=1 SHALL produce continuous output, no FILL.

Reset
REQ-028 On reset: FIFO empty, state IDLE, phase 0, axis_out_tvalid=0, axis_out_tdata=0, axis_out_tlast=0, underflow_cnt=0, axis_in_tready=1 (combinational from empty FIFO).
REQ-029 Reset asserted mid-symbol SHALL discard buffered and in-flight symbols; after release, behaviour identical to power-up.

Verification
REQ-030 SPS=4, hold, tready=1: one symbol 32'h6665999B tlast=1 -> 4 beats 6665999B, tlast on 4th only, then tvalid=0, underflow_cnt=0.
REQ-031 SPS=4, zero_stuff=1: symbol 32'h999B6665 tlast=1 -> beats 999B6665, 0, 0, 0; tlast on 4th.
REQ-032 Symbol A=32'h66656665 tlast=0, 10 idle cycles, B=32'h999B999B tlast=1 -> A x4, zero beats until B loaded, B x4 with tlast; underflow_cnt=1.
REQ-033 Three symbols presented back-to-back, axis_out_tready toggling 1/0 -> after 2 accepts while first symbol outputs, in_tready=0; each symbol exactly 4 beats, data stable during stalls, order preserved.
REQ-034 Reset pulse at phase 2 of a hold symbol with one symbol buffered -> next cycle tvalid=0, tdata=0, in_tready=1, underflow_cnt=0; no buffered symbol emitted after release.
